dmem_responder: RTL and testbench

- Memory-side responder for the core's load/store request interface. The core (initiator) issues a request; this block services it from an internal byte-enabled word array and returns a response after a programmable latency.
- Replaces the zero-latency RAM path when we need to exercise core stall handling.
- Sits under top beside the instruction RAM. The array is hex-preloadable by benches using word indexing, the same as the existing RAM.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Core <-> data memory request/response bus.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Core side: issues requests, accepts responses.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Memory side: accepts requests, returns responses.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data memory responder: byte-enabled word array answering one request at a
// time after a programmable number of wait cycles.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MEM_SIZE  = 32'h2024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int unsigned WORDS    = MEM_SIZE / 4;
  localparam int unsigned IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] LAST_OFF = 32'(WORDS * 4 - 1);
  localparam bit          HAS_WAIT = (LATENCY != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Word array, word-indexed so benches can hex-preload it directly.
  logic [31:0] mem [WORDS];

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_we;
  logic [IDX_W-1:0]   r_idx;
  logic               r_in_range;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic [31:0]        r_resp_rdata;
  logic               r_resp_err;
  logic               w_req_ready_nxt;
  logic               w_resp_valid_nxt;
  logic [31:0]        w_resp_rdata_nxt;
  logic               w_resp_err_nxt;

  logic [31:0]        w_off;
  logic               w_in_range;
  logic [IDX_W-1:0]   w_idx;
  logic               w_accept;
  logic               w_wr_en;

  // Range check on the offset so an address below BASE_ADDR cannot wrap in.
  assign w_off      = bus.req_addr - BASE_ADDR;
  assign w_in_range = (bus.req_addr >= BASE_ADDR) && (w_off <= LAST_OFF);
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_accept   = (r_state == S_IDLE) && r_req_ready && bus.req_valid;
  assign w_wr_en    = w_accept && rst_n && bus.req_we && w_in_range;

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = HAS_WAIT ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt <= CNT_W'(1)) w_state_nxt = S_RESP;
      S_RESP: if (bus.resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the wait counter.
  always_comb begin
    w_cnt_nxt        = r_cnt;
    w_req_ready_nxt  = (w_state_nxt == S_IDLE);
    w_resp_valid_nxt = (w_state_nxt == S_RESP);
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    case (r_state)
      S_IDLE: begin
        w_resp_rdata_nxt = 32'd0;
        w_resp_err_nxt   = 1'b0;
        if (w_accept) begin
          w_cnt_nxt = CNT_W'(LATENCY);
          if (!HAS_WAIT) begin
            w_resp_rdata_nxt = (!bus.req_we && w_in_range) ? mem[w_idx] : 32'd0;
            w_resp_err_nxt   = !w_in_range;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_resp_rdata_nxt = (!r_we && r_in_range) ? mem[r_idx] : 32'd0;
          w_resp_err_nxt   = !r_in_range;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          w_resp_rdata_nxt = 32'd0;
          w_resp_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_resp_rdata_nxt = 32'd0;
        w_resp_err_nxt   = 1'b0;
      end
    endcase
  end

  // Output, counter and request-latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_idx        <= '0;
      r_in_range   <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
      if (w_accept) begin
        r_we       <= bus.req_we;
        r_idx      <= w_idx;
        r_in_range <= w_in_range;
      end
    end
  end

  // Store commit on the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_wstrb[b]) mem[w_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=0 instances.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_if bus2();
  dmem_if bus0();

  dmem_responder #(.LATENCY(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  dmem_responder #(.LATENCY(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s timed out", tag);
  endtask

  task automatic set_req(input bit l0, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] s);
    if (l0) begin
      bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a;
      bus0.req_wdata = wd; bus0.req_wstrb = s;
    end else begin
      bus2.req_valid = v; bus2.req_we = we; bus2.req_addr = a;
      bus2.req_wdata = wd; bus2.req_wstrb = s;
    end
  endtask

  task automatic set_rr(input bit l0, input logic rr);
    if (l0) bus0.resp_ready = rr; else bus2.resp_ready = rr;
  endtask

  function automatic logic rdy(input bit l0);
    return l0 ? bus0.req_ready : bus2.req_ready;
  endfunction

  function automatic logic vld(input bit l0);
    return l0 ? bus0.resp_valid : bus2.resp_valid;
  endfunction

  // One full transaction with resp_ready high; edges counts the accept edge as 1.
  task automatic do_req(input bit l0, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output int edges, output logic [31:0] rdata, output logic err);
    int  n;
    bit  got;
    edges = 0;
    rdata = 'x;
    err   = 1'bx;
    @(negedge clk);
    set_req(l0, 1'b1, we, addr, wdata, strb);
    set_rr(l0, 1'b1);
    n = 0;
    while (!rdy(l0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(l0)) begin
      timeout("accept");
      set_req(l0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      return;
    end
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    set_req(l0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      if (vld(l0)) begin
        got   = 1'b1;
        rdata = l0 ? bus0.resp_rdata : bus2.resp_rdata;
        err   = l0 ? bus0.resp_err : bus2.resp_err;
      end else begin
        @(posedge clk);
        edges++;
        @(negedge clk);
        n++;
      end
    end
    if (!got) begin
      timeout("response");
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic load(input bit l0, input logic [31:0] addr, input logic [31:0] exp,
                      input logic exp_err, input string tag);
    int          e;
    logic [31:0] d;
    logic        r;
    do_req(l0, 1'b0, addr, 32'd0, 4'd0, e, d, r);
    chk({tag, "_rdata"}, d, exp);
    chk({tag, "_err"}, 32'(r), 32'(exp_err));
  endtask

  task automatic store(input bit l0, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] s, input logic exp_err, input string tag);
    int          e;
    logic [31:0] d;
    logic        r;
    do_req(l0, 1'b1, addr, wd, s, e, d, r);
    chk({tag, "_rdata"}, d, 32'd0);
    chk({tag, "_err"}, 32'(r), 32'(exp_err));
  endtask

  task automatic wait_vld(input bit l0, input string tag);
    int n;
    n = 0;
    while (!vld(l0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!vld(l0)) timeout(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e;
    int          acc;
    int          last;
    logic [31:0] d;
    logic        r;

    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_rr(1'b0, 1'b0);
    set_rr(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_req_ready", 32'(bus2.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus2.resp_valid), 32'd0);
    chk("rst_rdata", bus2.resp_rdata, 32'd0);
    chk("rst_err", 32'(bus2.resp_err), 32'd0);
    chk("rst0_req_ready", 32'(bus0.req_ready), 32'd1);
    chk("rst0_resp_valid", 32'(bus0.resp_valid), 32'd0);

    // Store then load, latency 2: response on the third edge counting accept
    do_req(1'b0, 1'b1, 32'h8000_1010, 32'h1234_5678, 4'hF, e, d, r);
    chk("st_edges", 32'(e), 32'd3);
    chk("st_rdata", d, 32'd0);
    chk("st_err", 32'(r), 32'd0);
    do_req(1'b0, 1'b0, 32'h8000_1010, 32'd0, 4'd0, e, d, r);
    chk("ld_edges", 32'(e), 32'd3);
    chk("ld_rdata", d, 32'h1234_5678);
    chk("ld_err", 32'(r), 32'd0);
    load(1'b0, 32'h8000_1013, 32'h1234_5678, 1'b0, "ld_lowbits");

    // Byte strobes
    store(1'b0, 32'h8000_0010, 32'hAABB_CCDD, 4'hF, 1'b0, "st_w4");
    store(1'b0, 32'h8000_0011, 32'h0000_EE00, 4'b0010, 1'b0, "st_b1");
    load(1'b0, 32'h8000_0010, 32'hAABB_EEDD, 1'b0, "ld_strb");
    store(1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, "st_nostrb");
    load(1'b0, 32'h8000_0010, 32'hAABB_EEDD, 1'b0, "ld_nostrb");

    // Backpressure: response stalled 5 cycles, second request held meanwhile
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 32'h8000_1010, 32'd0, 4'd0);
    set_rr(1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'd0, 4'd0);
    wait_vld(1'b0, "bp_resp");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus2.resp_valid), 32'd1);
      chk("bp_rdata", bus2.resp_rdata, 32'h1234_5678);
      chk("bp_err", 32'(bus2.resp_err), 32'd0);
      chk("bp_req_ready", 32'(bus2.req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    set_rr(1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_valid", 32'(bus2.resp_valid), 32'd0);
    chk("bp_after_ready", 32'(bus2.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_second_accepted", 32'(bus2.req_ready), 32'd0);
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    wait_vld(1'b0, "bp_second_resp");
    chk("bp_second_rdata", bus2.resp_rdata, 32'hAABB_EEDD);
    @(posedge clk);

    // Out of range
    load(1'b0, 32'h7FFF_FFFC, 32'd0, 1'b1, "oor_below");
    load(1'b0, 32'h0000_0010, 32'd0, 1'b1, "oor_zero");
    store(1'b0, 32'h8000_2020, 32'hCAFE_F00D, 4'hF, 1'b0, "st_last");
    store(1'b0, 32'h8000_2024, 32'hDEAD_BEEF, 4'hF, 1'b1, "oor_st_end");
    load(1'b0, 32'h8000_2024, 32'd0, 1'b1, "oor_ld_end");
    load(1'b0, 32'h8000_2023, 32'hCAFE_F00D, 1'b0, "ld_last");
    store(1'b0, 32'h8000_4010, 32'h1111_1111, 4'hF, 1'b1, "oor_st_alias");
    load(1'b0, 32'h8000_0010, 32'hAABB_EEDD, 1'b0, "ld_noalias");

    // Latency 0 instance
    do_req(1'b1, 1'b1, 32'h8000_0020, 32'h5A5A_5A5A, 4'hF, e, d, r);
    chk("l0_st_edges", 32'(e), 32'd1);
    do_req(1'b1, 1'b0, 32'h8000_0020, 32'd0, 4'd0, e, d, r);
    chk("l0_ld_edges", 32'(e), 32'd1);
    chk("l0_ld_rdata", d, 32'h5A5A_5A5A);
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b0, 32'h8000_0020, 32'd0, 4'd0);
    set_rr(1'b1, 1'b1);
    acc  = 0;
    last = -1;
    for (int k = 0; k < 10; k++) begin
      if (bus0.req_ready) begin
        acc++;
        last = k;
      end
      if (k == 1) begin
        chk("l0_b2b_valid", 32'(bus0.resp_valid), 32'd1);
        chk("l0_b2b_rdata", bus0.resp_rdata, 32'h5A5A_5A5A);
      end
      @(posedge clk);
      @(negedge clk);
    end
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("l0_b2b_count", 32'(acc), 32'd5);
    chk("l0_b2b_last", 32'(last), 32'd8);

    // Async reset mid-WAIT
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 32'h8000_1010, 32'd0, 4'd0);
    set_rr(1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("wait_req_ready", 32'(bus2.req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wait_ready", 32'(bus2.req_ready), 32'd1);
    chk("arst_wait_valid", 32'(bus2.resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset while a response is stalled
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 32'h8000_1010, 32'd0, 4'd0);
    set_rr(1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    wait_vld(1'b0, "arst_resp");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 32'(bus2.resp_valid), 32'd0);
    chk("arst_resp_rdata", bus2.resp_rdata, 32'd0);
    chk("arst_resp_ready", 32'(bus2.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Service after reset; earlier stores persist
    load(1'b0, 32'h8000_1010, 32'h1234_5678, 1'b0, "post_rst_ld1");
    load(1'b0, 32'h8000_0010, 32'hAABB_EEDD, 1'b0, "post_rst_ld2");
    load(1'b1, 32'h8000_0020, 32'h5A5A_5A5A, 1'b0, "post_rst_l0");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
